// File: rtl/transpose_stream_pingpong.sv
// Streaming ROWS x COLS tile transpose with two ping-pong tile banks.
// One bank fills while the other drains column-major, or row-major when the tile was written in bypass mode.
module transpose_stream_pingpong #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic                  mode_bypass,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  err_last
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int OC_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int OR_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [OR_W-1:0]  OR_LAST  = OR_W'(ROWS - 1);

  logic [DATA_WIDTH-1:0] mem_reg [2][N];

  logic [1:0]       full_reg, full_next;
  logic [1:0]       mode_reg, mode_next;
  logic             wsel_reg, wsel_next;
  logic             rsel_reg, rsel_next;
  logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
  logic [IDX_W-1:0] rd_cnt_reg, rd_cnt_next;
  logic [OC_W-1:0]  oc_reg, oc_next;
  logic [OR_W-1:0]  orow_reg, orow_next;
  logic             err_reg, err_next;

  logic             wr_fire, wr_end, rd_fire, rd_end;
  logic [IDX_W-1:0] tr_idx, rd_idx;

  assign in_ready  = ~full_reg[wsel_reg];
  assign wr_fire   = in_valid & in_ready;
  assign wr_end    = (wr_idx_reg == IDX_LAST);
  assign out_valid = full_reg[rsel_reg];
  assign rd_fire   = out_valid & out_ready;
  assign rd_end    = (rd_cnt_reg == IDX_LAST);

  // Computed at integer width so orow*COLS never truncates before the final resize.
  assign tr_idx   = IDX_W'(int'(orow_reg) * COLS + int'(oc_reg));
  assign rd_idx   = mode_reg[rsel_reg] ? rd_cnt_reg : tr_idx;
  assign out_data = mem_reg[rsel_reg][rd_idx];
  assign out_last = out_valid & rd_end;
  assign err_last = err_reg;

  always_comb begin
    full_next   = full_reg;
    mode_next   = mode_reg;
    wsel_next   = wsel_reg;
    rsel_next   = rsel_reg;
    wr_idx_next = wr_idx_reg;
    rd_cnt_next = rd_cnt_reg;
    oc_next     = oc_reg;
    orow_next   = orow_reg;
    err_next    = err_reg;

    if (wr_fire) begin
      if (wr_idx_reg == '0) mode_next[wsel_reg] = mode_bypass;
      if (in_last != wr_end) err_next = 1'b1;
      if (wr_end) begin
        full_next[wsel_reg] = 1'b1;
        wsel_next           = ~wsel_reg;
        wr_idx_next         = '0;
      end else begin
        wr_idx_next = wr_idx_reg + 1'b1;
      end
    end

    // Write and read never target the same bank in one cycle: one needs it empty, the other full.
    if (rd_fire) begin
      if (rd_end) begin
        full_next[rsel_reg] = 1'b0;
        rsel_next           = ~rsel_reg;
        rd_cnt_next         = '0;
        oc_next             = '0;
        orow_next           = '0;
      end else begin
        rd_cnt_next = rd_cnt_reg + 1'b1;
        if (orow_reg == OR_LAST) begin
          orow_next = '0;
          oc_next   = oc_reg + 1'b1;
        end else begin
          orow_next = orow_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      full_reg   <= '0;
      mode_reg   <= '0;
      wsel_reg   <= 1'b0;
      rsel_reg   <= 1'b0;
      wr_idx_reg <= '0;
      rd_cnt_reg <= '0;
      oc_reg     <= '0;
      orow_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      full_reg   <= full_next;
      mode_reg   <= mode_next;
      wsel_reg   <= wsel_next;
      rsel_reg   <= rsel_next;
      wr_idx_reg <= wr_idx_next;
      rd_cnt_reg <= rd_cnt_next;
      oc_reg     <= oc_next;
      orow_reg   <= orow_next;
      err_reg    <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      always_ff @(posedge clk_p) begin
        if (wr_fire && (wsel_reg == 1'(gi))) mem_reg[gi][wr_idx_reg] <= in_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_transpose_stream_pingpong.sv
// Directed bench for transpose_stream_pingpong: a 2x3 and a 4x4 instance share one stimulus path
// selected by sel; a negedge monitor collects accepted outputs and checks the output hold rule.
module tb_transpose_stream_pingpong;

  typedef struct {
    bit           sel;
    bit           mode;
    int           base;
    int           bad_pos;
    bit           exp_err;
    logic [127:0] exp;
  } vec_t;

  logic clk_p = 1'b0;
  logic rst_n = 1'b0;
  bit   sel   = 1'b0;
  logic mode_bypass = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;

  logic in_ready, out_valid, out_last, err_last;
  logic [7:0] out_data;
  logic rdy_a, ov_a, ol_a, err_a, rdy_b, ov_b, ol_b, err_b;
  logic [7:0] od_a, od_b;
  logic iv_a, iv_b, or_a, or_b;

  assign iv_a = in_valid & ~sel;
  assign iv_b = in_valid & sel;
  assign or_a = out_ready & ~sel;
  assign or_b = out_ready & sel;
  assign in_ready  = sel ? rdy_b : rdy_a;
  assign out_valid = sel ? ov_b  : ov_a;
  assign out_data  = sel ? od_b  : od_a;
  assign out_last  = sel ? ol_b  : ol_a;
  assign err_last  = sel ? err_b : err_a;

  transpose_stream_pingpong #(.DATA_WIDTH(8), .ROWS(2), .COLS(3)) u_dut23 (
    .clk_p(clk_p), .rst_n(rst_n), .mode_bypass(mode_bypass), .in_valid(iv_a), .in_ready(rdy_a),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .out_last(ol_a), .err_last(err_a));

  transpose_stream_pingpong #(.DATA_WIDTH(8), .ROWS(4), .COLS(4)) u_dut44 (
    .clk_p(clk_p), .rst_n(rst_n), .mode_bypass(mode_bypass), .in_valid(iv_b), .in_ready(rdy_b),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .out_last(ol_b), .err_last(err_b));

  always #5 clk_p = ~clk_p;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int hold_err = 0;
  int stall_waits = 0;
  logic [7:0] dq[$];
  bit lq[$];
  int cq[$];
  bit hold_prev = 1'b0;
  logic [7:0] hold_data = '0;
  logic hold_last = 1'b0;
  vec_t vecs[6];

  always @(posedge clk_p) cyc++;

  always @(negedge clk_p) begin
    if (hold_prev && (out_valid !== 1'b1 || out_data !== hold_data || out_last !== hold_last))
      hold_err++;
    hold_prev = out_valid & ~out_ready;
    hold_data = out_data;
    hold_last = out_last;
    if (out_valid && out_ready) begin
      dq.push_back(out_data);
      lq.push_back(out_last);
      cq.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    dq.delete();
    lq.delete();
    cq.delete();
  endtask

  // Entered and left at posedge+1; holds the element until it is accepted.
  task automatic send(input logic [7:0] d, input logic m, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; mode_bypass = m; in_last = l;
    @(negedge clk_p);
    while (!in_ready && t < 200) begin
      t++;
      stall_waits++;
      @(negedge clk_p);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk_p); #1;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int t = 0;
    while (dq.size() < n && t < budget) begin
      @(posedge clk_p); #1;
      t++;
    end
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int n;
    int lerr;
    logic lst;
    n = v.sel ? 16 : 6;
    sel = v.sel;
    out_ready = 1'b1;
    #1;
    clear_q();
    for (int i = 0; i < n; i++) begin
      lst = (v.bad_pos >= 0) ? (i == v.bad_pos) : (i == n - 1);
      if (i == n - 1) chk("pre_last_out_valid", int'(out_valid), 0);
      send(8'(v.base + i), v.mode, lst);
      if (i == v.bad_pos) chk("err_last_set", int'(err_last), 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("latency_out_valid", int'(out_valid), 1);
    chk("first_out_data", int'(out_data), int'(v.exp[7:0]));
    wait_outputs(n, 100);
    chk("out_count", dq.size(), n);
    lerr = 0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("v%0d_data[%0d]", idx, k), (k < dq.size()) ? int'(dq[k]) : -1,
          int'(v.exp[k*8 +: 8]));
      if (k < lq.size() && lq[k] != (k == n - 1)) lerr++;
    end
    chk("out_last_pos", lerr, 0);
    chk("err_last_final", int'(err_last), int'(v.exp_err));
    $display("[TB] vector %0d sel=%0d mode=%0d base=%0d outputs=%0d err_last=%0d",
             idx, v.sel, v.mode, v.base, dq.size(), err_last);
  endtask

  initial begin
    int acc;
    int gap;
    int lerr;
    logic got;
    logic [7:0] ev;

    vecs[0] = '{1'b0, 1'b0, 0,  -1, 1'b0, 128'h050204010300};
    vecs[1] = '{1'b0, 1'b1, 0,  -1, 1'b0, 128'h050403020100};
    vecs[2] = '{1'b0, 1'b0, 16, -1, 1'b0, 128'h151214111310};
    vecs[3] = '{1'b0, 1'b0, 0,  2,  1'b1, 128'h050204010300};
    vecs[4] = '{1'b1, 1'b1, 32, -1, 1'b0, 128'h2f2e2d2c_2b2a2928_27262524_23222120};
    vecs[5] = '{1'b1, 1'b0, 128, -1, 1'b0, 128'h8f8b8783_8e8a8682_8d898581_8c888480};

    repeat (3) @(posedge clk_p);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_err_last", int'(err_last), 0);
    end
    @(posedge clk_p); #1;

    for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

    // Three 4x4 tiles back to back: neither stream may bubble.
    sel = 1'b1; out_ready = 1'b1; stall_waits = 0;
    clear_q();
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 16; i++) send(8'(16 * t + i), 1'b0, i == 15);
    in_valid = 1'b0; in_last = 1'b0;
    wait_outputs(48, 200);
    chk("stream_count", dq.size(), 48);
    chk("stream_in_waits", stall_waits, 0);
    gap = 0; lerr = 0;
    for (int k = 1; k < cq.size(); k++) if (cq[k] != cq[k-1] + 1) gap++;
    chk("stream_out_bubbles", gap, 0);
    for (int k = 0; k < 48; k++) begin
      ev = vecs[5].exp[(k % 16)*8 +: 8] - 8'h80 + 8'(16 * (k / 16));
      chk($sformatf("stream_data[%0d]", k), (k < dq.size()) ? int'(dq[k]) : -1, int'(ev));
      if (k < lq.size() && lq[k] != ((k % 16) == 15)) lerr++;
    end
    chk("stream_last_pos", lerr, 0);
    $display("[TB] stream 3x4x4 outputs=%0d bubbles=%0d", dq.size(), gap);

    // Consumer stalled for 40 cycles: exactly two tiles fit, then a random drain.
    sel = 1'b1; out_ready = 1'b0; hold_err = 0; acc = 0;
    clear_q();
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 8'(acc); in_last = ((acc % 16) == 15); mode_bypass = 1'b0;
      @(negedge clk_p);
      got = in_ready;
      @(posedge clk_p); #1;
      if (got) acc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("stall_accepted", acc, 32);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_no_output", dq.size(), 0);
    for (int t = 0; t < 600 && dq.size() < 32; t++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk_p); #1;
    end
    out_ready = 1'b1;
    chk("drain_count", dq.size(), 32);
    for (int k = 0; k < 32; k++) begin
      ev = vecs[5].exp[(k % 16)*8 +: 8] - 8'h80 + 8'(16 * (k / 16));
      chk($sformatf("drain_data[%0d]", k), (k < dq.size()) ? int'(dq[k]) : -1, int'(ev));
    end
    chk("hold_stable", hold_err, 0);
    $display("[TB] stall accepted=%0d drained=%0d hold_err=%0d", acc, dq.size(), hold_err);

    // Reset mid-tile on the 2x3 instance, whose err_last is still set from the bad in_last tile.
    sel = 1'b0; out_ready = 1'b1;
    #1;
    chk("pre_reset_err_last", int'(err_last), 1);
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk_p); #1;
    rst_n = 1'b0;
    @(posedge clk_p); #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_err_last", int'(err_last), 0);
    chk("mid_rst_out_last", int'(out_last), 0);
    run_vector(6, vecs[0]);
    repeat (20) @(posedge clk_p);
    #1;
    chk("no_leftover", dq.size(), 6);
    $display("[TB] reset mid-tile outputs=%0d", dq.size());

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
